// File: rtl/clkgate_pkg.sv
// -----------------------------------------------------------------------------
// clkgate_pkg
//   Shared definitions for the clock-gate enable controller.
//   - state_e           : controller state (ST_ON, ST_OFF, ST_WAKE)
//   - DEF_IDLE_CYCLES   : default consecutive idle cycles before gating
//   - DEF_WAKE_CYCLES   : default cycles spent in WAKE before accepting work
//   - PERF_W            : width of the optional performance counters
// -----------------------------------------------------------------------------
package clkgate_pkg;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int PERF_W          = 32;

endpackage : clkgate_pkg

// File: rtl/clkgate_down_cnt.sv
// -----------------------------------------------------------------------------
// clkgate_down_cnt
//   Loadable down-counter with a "count equals 1" flag. Used for the idle
//   timer and the wake timer of the clock-gate enable controller.
//
// Ports:
//   clock     in   free-running clock
//   reset_n   in   asynchronous active-low reset (count -> RESET_VAL)
//   load      in   load load_val this cycle (wins over dec)
//   load_val  in   value to load
//   dec       in   decrement this cycle; holds at zero
//   is_one    out  count currently equals 1
// -----------------------------------------------------------------------------
module clkgate_down_cnt #(
  parameter int           W         = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      // Holding at zero keeps an idle counter from wrapping to all-ones.
      cnt <= cnt - W'(1);
    end
  end

  assign is_one = (cnt == W'(1));

endmodule : clkgate_down_cnt

// File: rtl/clkgate_en_ctrl.sv
// -----------------------------------------------------------------------------
// clkgate_en_ctrl
//   Generates the registered enable (E) and test enable (TE) for one
//   clock-gating cell. The gated clock is switched off after IDLE_CYCLES
//   consecutive idle cycles and restarted on activity; new requests are
//   stalled for WAKE_CYCLES cycles while the gated clock restarts.
//   All logic here runs on the free-running clock.
//
// Parameters:
//   IDLE_CYCLES  consecutive idle cycles before gating (>= 1)
//   WAKE_CYCLES  cycles spent in WAKE before req_ready rises (>= 1)
//
// Ports:
//   clock             in   free-running clock
//   reset_n           in   asynchronous active-low reset
//   req_valid         in   requester has an access pending (held until accepted)
//   req_ready         out  access accepted this cycle when req_valid is high
//   busy_in           in   downstream pipeline still has work in flight
//   force_on          in   software override keeping the clock on
//   scan_mode         in   DFT scan mode
//   gate_en           out  registered E to the gating cell
//   gate_te           out  TE to the gating cell (copy of scan_mode)
//   gated             out  status: controller is in OFF
//   state_dbg         out  current controller state (clkgate_pkg::state_e)
//   perf_off_cycles   out  saturating count of cycles spent in OFF
//   perf_wake_events  out  saturating count of OFF->WAKE transitions
//
// Build option:
//   CLKGATE_PERF_EN   when defined, adds perf_off_cycles / perf_wake_events.
//
// Handshake: an access transfers on a rising clock edge where req_valid and
// req_ready are both high. req_ready is a pure decode of registered state and
// never depends combinationally on req_valid; the requester holds req_valid
// (and its payload) until that transfer edge.
// -----------------------------------------------------------------------------
module clkgate_en_ctrl #(
  parameter int IDLE_CYCLES = clkgate_pkg::DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = clkgate_pkg::DEF_WAKE_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       busy_in,
  input  logic       force_on,
  input  logic       scan_mode,
  output logic       gate_en,
  output logic       gate_te,
  output logic       gated,
  output logic [1:0] state_dbg
`ifdef CLKGATE_PERF_EN
  ,
  output logic [clkgate_pkg::PERF_W-1:0] perf_off_cycles,
  output logic [clkgate_pkg::PERF_W-1:0] perf_wake_events
`endif
);

  import clkgate_pkg::*;

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  state_e state;
  logic   act;

  logic   idle_load;
  logic   idle_dec;
  logic   idle_one;
  logic   wake_load;
  logic   wake_dec;
  logic   wake_one;

  // Any of these keeps the gated clock running.
  assign act = req_valid | busy_in | force_on;

  // ---------------------------------------------------------------------------
  // Idle timer: reloads on activity in ON and when WAKE hands back to ON.
  // It stops at 1 when the FSM leaves for OFF, so it never underflows.
  // ---------------------------------------------------------------------------
  assign idle_load = ((state == ST_ON) && act) ||
                     ((state == ST_WAKE) && wake_one);
  assign idle_dec  = (state == ST_ON) && !act && !idle_one;

  clkgate_down_cnt #(
    .W         (IDLE_W),
    .RESET_VAL (IDLE_W'(IDLE_CYCLES))
  ) u_idle_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (idle_load),
    .load_val (IDLE_W'(IDLE_CYCLES)),
    .dec      (idle_dec),
    .is_one   (idle_one)
  );

  // ---------------------------------------------------------------------------
  // Wake timer: loaded on the OFF->WAKE edge, counts down through WAKE and
  // returns to zero as the FSM re-enters ON.
  // ---------------------------------------------------------------------------
  assign wake_load = (state == ST_OFF) && act;
  assign wake_dec  = (state == ST_WAKE);

  clkgate_down_cnt #(
    .W         (WAKE_W),
    .RESET_VAL ('0)
  ) u_wake_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (wake_load),
    .load_val (WAKE_W'(WAKE_CYCLES)),
    .dec      (wake_dec),
    .is_one   (wake_one)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM. gate_en, req_ready and gated are registered alongside the
  // state so E only ever changes on the rising edge and the gating cell's
  // low-phase latch always sees a settled value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ON;
      gate_en   <= 1'b1;
      req_ready <= 1'b1;
      gated     <= 1'b0;
    end else begin
      unique case (state)
        ST_ON: begin
          // Activity on the last idle cycle wins: stay ON (timer reloads).
          if (!act && idle_one) begin
            state     <= ST_OFF;
            gate_en   <= 1'b0;
            req_ready <= 1'b0;
            gated     <= 1'b1;
          end
        end
        ST_OFF: begin
          if (act) begin
            state   <= ST_WAKE;
            gate_en <= 1'b1;
            gated   <= 1'b0;
          end
        end
        ST_WAKE: begin
          // WAKE always runs to completion, even if activity disappears.
          if (wake_one) begin
            state     <= ST_ON;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_ON;
          gate_en   <= 1'b1;
          req_ready <= 1'b1;
          gated     <= 1'b0;
        end
      endcase
    end
  end

  // Scan only forces the cell transparent; the FSM keeps running normally.
  assign gate_te   = scan_mode;
  assign state_dbg = state;

`ifdef CLKGATE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_off_cycles  <= '0;
      perf_wake_events <= '0;
    end else begin
      if ((state == ST_OFF) && (perf_off_cycles != '1)) begin
        perf_off_cycles <= perf_off_cycles + PERF_W'(1);
      end
      if (wake_load && (perf_wake_events != '1)) begin
        perf_wake_events <= perf_wake_events + PERF_W'(1);
      end
    end
  end
`endif

endmodule : clkgate_en_ctrl
